// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central hazard and sequencing controller for the five-stage pipeline.
// A shadow scoreboard follows the destination register of the instructions in
// EX, MEM and WB. From it and the ID-stage operands the block derives:
//   - load-use stalls (hold PC and IF/ID, bubble into ID/EX),
//   - ID-stage forwarding selects,
//   - taken-branch flushes of IF/ID,
//   - whole-pipeline freezes while data memory is busy.
// Stall, flush and freeze events are counted, and a sticky flag reports a
// memory access that kept the pipeline frozen for MEM_TIMEOUT cycles.
//
// Parameters
//   MEM_TIMEOUT             freeze-run length at which mem_timeout sets
// Ports
//   clk, rst                clock, synchronous active-high reset
//   id_valid                ID holds a real instruction
//   id_rsAddress/rtAddress  ID source register numbers
//   id_rsUsed/rtUsed        ID actually reads that source
//   id_shouldWriteRegister  ID instruction writes the register file
//   id_registerWriteAddress ID destination register
//   id_isLoad               ID instruction is a load
//   id_isBranchTaken        branch/jump resolved taken in ID
//   mem_wait                MEM access outstanding
//   pc_shouldStall          hold PC
//   ifid_shouldStall        hold IF/ID
//   ifid_shouldFlush        load a NOP into IF/ID
//   id_shouldStall          load a bubble into ID/EX
//   pipeline_freeze         hold every pipeline register
//   id_rsForward/rtForward  0 regfile, 1 EX, 2 MEM, 3 WB
//   stallCount/flushCount/freezeCount  wrapping event counters
//   mem_timeout             sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rsAddress,
    input  logic [4:0]  id_rtAddress,
    input  logic        id_rsUsed,
    input  logic        id_rtUsed,
    input  logic        id_shouldWriteRegister,
    input  logic [4:0]  id_registerWriteAddress,
    input  logic        id_isLoad,
    input  logic        id_isBranchTaken,
    input  logic        mem_wait,
    output logic        pc_shouldStall,
    output logic        ifid_shouldStall,
    output logic        ifid_shouldFlush,
    output logic        id_shouldStall,
    output logic        pipeline_freeze,
    output logic [1:0]  id_rsForward,
    output logic [1:0]  id_rtForward,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount,
    output logic [31:0] freezeCount,
    output logic        mem_timeout
);

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic       isLoad;
    } sbEntry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = MEM_TIMEOUT[15:0];

    sbEntry_t exEntry_r;
    sbEntry_t memEntry_r;
    sbEntry_t wbEntry_r;
    sbEntry_t idEntry_s;
    state_t   state_r;
    state_t   stateNext_s;
    logic     freeze_s;
    logic     loadUse_s;
    logic [1:0]  rsSelect_s;
    logic [1:0]  rtSelect_s;
    logic [15:0] runCount_r;
    logic [15:0] runNext_s;

    // An entry matches a source only if it really writes a nonzero register
    // that the ID instruction really reads; r0 therefore never forwards.
    function automatic logic entryMatches(input sbEntry_t e, input logic [4:0] src,
                                          input logic used);
        return used & e.we & (e.addr != 5'd0) & (e.addr == src);
    endfunction

    // Nearest producer wins: EX is younger than MEM, MEM younger than WB.
    function automatic logic [1:0] forwardSelect(input sbEntry_t ex, input sbEntry_t mem,
                                                 input sbEntry_t wb, input logic [4:0] src,
                                                 input logic used);
        logic [1:0] sel;
        if (entryMatches(ex, src, used)) begin
            sel = 2'd1;
        end else if (entryMatches(mem, src, used)) begin
            sel = 2'd2;
        end else if (entryMatches(wb, src, used)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Hazard detection and forwarding selects from the scoreboard and ID operands.
    always_comb begin
        freeze_s   = mem_wait & ~rst;
        loadUse_s  = id_valid & exEntry_r.isLoad &
                     (entryMatches(exEntry_r, id_rsAddress, id_rsUsed) |
                      entryMatches(exEntry_r, id_rtAddress, id_rtUsed));
        rsSelect_s = forwardSelect(exEntry_r, memEntry_r, wbEntry_r, id_rsAddress, id_rsUsed);
        rtSelect_s = forwardSelect(exEntry_r, memEntry_r, wbEntry_r, id_rtAddress, id_rtUsed);
        idEntry_s.we     = id_shouldWriteRegister;
        idEntry_s.addr   = id_registerWriteAddress;
        idEntry_s.isLoad = id_isLoad;
    end

    // Control outputs: reset forces zero, then freeze beats stall beats flush.
    always_comb begin
        pc_shouldStall   = 1'b0;
        ifid_shouldStall = 1'b0;
        ifid_shouldFlush = 1'b0;
        id_shouldStall   = 1'b0;
        pipeline_freeze  = 1'b0;
        id_rsForward     = 2'd0;
        id_rtForward     = 2'd0;
        if (rst) begin
            pipeline_freeze = 1'b0;
        end else begin
            id_rsForward = rsSelect_s;
            id_rtForward = rtSelect_s;
            if (freeze_s) begin
                pipeline_freeze  = 1'b1;
                pc_shouldStall   = 1'b1;
                ifid_shouldStall = 1'b1;
            end else if (loadUse_s) begin
                // A stalled branch must not flush; it resolves again next cycle.
                pc_shouldStall   = 1'b1;
                ifid_shouldStall = 1'b1;
                id_shouldStall   = 1'b1;
            end else begin
                ifid_shouldFlush = id_valid & id_isBranchTaken;
            end
        end
    end

    // Scoreboard advance; a bubble or an invalid ID slot enters EX as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            exEntry_r  <= '0;
            memEntry_r <= '0;
            wbEntry_r  <= '0;
        end else if (!freeze_s) begin
            exEntry_r  <= (id_shouldStall || !id_valid) ? sbEntry_t'(7'd0) : idEntry_s;
            memEntry_r <= exEntry_r;
            wbEntry_r  <= memEntry_r;
        end else begin
            exEntry_r  <= exEntry_r;
            memEntry_r <= memEntry_r;
            wbEntry_r  <= wbEntry_r;
        end
    end

    // Sequencing FSM next state.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            RUN: begin
                if (freeze_s) begin
                    stateNext_s = FREEZE;
                end else if (loadUse_s) begin
                    stateNext_s = STALL;
                end else begin
                    stateNext_s = RUN;
                end
            end
            STALL: begin
                if (freeze_s) begin
                    stateNext_s = FREEZE;
                end else begin
                    stateNext_s = RUN;
                end
            end
            FREEZE: begin
                if (!mem_wait) begin
                    stateNext_s = RUN;
                end else begin
                    stateNext_s = FREEZE;
                end
            end
            default: stateNext_s = RUN;
        endcase
    end

    // Sequencing FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount  <= 32'd0;
            flushCount  <= 32'd0;
            freezeCount <= 32'd0;
        end else begin
            stallCount  <= stallCount  + {31'd0, id_shouldStall};
            flushCount  <= flushCount  + {31'd0, ifid_shouldFlush};
            freezeCount <= freezeCount + {31'd0, pipeline_freeze};
        end
    end

    // Next freeze-run length: cleared outside a freeze, saturating inside one.
    always_comb begin
        runNext_s = 16'd0;
        if (!freeze_s) begin
            runNext_s = 16'd0;
        end else if (runCount_r == 16'hFFFF) begin
            runNext_s = runCount_r;
        end else begin
            runNext_s = runCount_r + 16'd1;
        end
    end

    // Freeze-run counter and sticky timeout flag; the flag rises on the same
    // edge that completes the MEM_TIMEOUT-th consecutive freeze cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            runCount_r  <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            runCount_r <= runNext_s;
            if (freeze_s && (runNext_s == TIMEOUT_LIMIT)) begin
                mem_timeout <= 1'b1;
            end else begin
                mem_timeout <= mem_timeout;
            end
        end
    end

endmodule
